ts4231_pulse_capture: RTL and testbench
=======================================

Name: ts4231_pulse_capture

Overview:
- Per-sensor front end between one TS4231 light-to-digital converter (e/d pins) and the lighthouse pulse-processing core.
- Synchronises the sensor's envelope (e) and data (d) lines and detects each light pulse.
- For each pulse, emits one record on a valid/ready stream to the downstream merger/decoder: start timestamp, width, d-edge count and flags.
- Records are buffered in a small FIFO; one instance per sensor, four in the top level.

Parameters:
- TS_W, 24, width of shared timestamp input and record timestamp field
- WIDTH_W, 16, width of pulse-width field in clock cycles (saturating)
- EDGE_W, 8, width of d-transition counter (saturating)
- MIN_WIDTH, 4, pulses shorter than this many cycles are discarded as glitches
- FIFO_DEPTH, 4, record FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, 48 MHz in the lighthouse build
- reset  in  1  synchronous, active-high reset
- io_e  in  1  raw TS4231 envelope; low = light present
- io_d  in  1  raw TS4231 data line
- io_timestamp  in  TS_W  shared free-running timestamp, increments once per clk
- io_pulse_valid  out  1  record available
- io_pulse_ready  in  1  consumer accepts record
- io_pulse_timestamp  out  TS_W  io_timestamp value in the cycle the synced envelope went active
- io_pulse_width  out  WIDTH_W  cycles the synced envelope was active
- io_pulse_edges  out  EDGE_W  synced d transitions counted while envelope active
- io_pulse_saturated  out  1  width or edge counter saturated during this pulse
- io_overflow  out  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on reset.
- Input synchronisation:
  - io_e and io_d each pass through a 2-flop synchroniser.
  - Synchroniser flops reset to 1; an idle sensor therefore reads no light.
  - env = NOT e_sync.
  - Latency from a raw pin edge to env is 2 cycles. No timestamp compensation is applied.
- State machine:
  - IDLE:
    - On env rising (env=1, previous env=0): capture start_ts <= io_timestamp, width <= 1, edges <= 0, sat <= 0, then go to PULSE.
    - env already 1 after reset does not start a pulse; an env rising edge is required.
  - PULSE, each cycle with env=1:
    - width increments, saturating at 2^WIDTH_W-1; sat is set on reaching the saturated value.
    - A d_sync change versus the previous cycle increments edges, saturating at 2^EDGE_W-1 and setting sat.
  - PULSE, cycle with env=0:
    - If width >= MIN_WIDTH, push the record {start_ts, width, edges, sat}.
    - Otherwise discard the record.
    - Go to IDLE. The end cycle is not counted in width.
  - A new rising edge is recognised in the cycle immediately after the push, which gives back-to-back pulses with no dead cycle.
- FIFO and output handshake:
  - First-word fall-through: a record is visible on the outputs the cycle after its push.
  - Outputs are stable while valid=1 and ready=0.
  - A record transfers when valid and ready are both 1.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees the slot the push needs.
  - Push while full and no pop: the new record is dropped and io_overflow is set. io_overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- Reset values:
  - io_pulse_valid=0, io_overflow=0, FIFO empty, state IDLE.
  - All data outputs are 0.
  - Reset mid-pulse discards the partial record.
- Timestamp wrap: start_ts is the raw io_timestamp value. Wrap handling belongs downstream.

Test Plan:
- Reset, e=1, d=0, ready=1, run 1000 cycles -> io_pulse_valid stays 0; io_overflow=0.
- e low for 100 cycles starting when io_timestamp=0x000010, d toggled 6 times inside, ready=1 -> one record with timestamp=0x000012, width=100, edges=6, saturated=0.
- e low for 3 cycles (below MIN_WIDTH=4), then a 4-cycle pulse -> exactly one record, width=4.
- Six 20-cycle pulses 10 cycles apart with ready=0 -> valid=1, first four records held in order, io_overflow=1. Then ready=1 -> exactly four records drain, then valid=0.
- e low for 70000 cycles -> width=65535, saturated=1.
- Reset asserted at cycle 50 of a 100-cycle pulse -> no record emitted. The next full pulse records normally.
- FIFO full, ready=1 in the cycle a new pulse ends -> pop and push both occur; no overflow; FIFO stays full with the new record last.

Source files
------------

// File: rtl/ts4231_pulse_capture.sv
// TS4231 per-sensor pulse front end: synchronises e/d, measures each light
// pulse and queues {start timestamp, width, d-edge count, saturated} records
// behind a first-word-fall-through FIFO with a valid/ready output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no light; waiting for a rising edge of the synced envelope
// PULSE  | envelope active; width and d edges are being counted
module ts4231_pulse_capture #(
    parameter int TS_W       = 24,
    parameter int WIDTH_W    = 16,
    parameter int EDGE_W     = 8,
    parameter int MIN_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_e,
    input  logic               io_d,
    input  logic [TS_W-1:0]    io_timestamp,
    output logic               io_pulse_valid,
    input  logic               io_pulse_ready,
    output logic [TS_W-1:0]    io_pulse_timestamp,
    output logic [WIDTH_W-1:0] io_pulse_width,
    output logic [EDGE_W-1:0]  io_pulse_edges,
    output logic               io_pulse_saturated,
    output logic               io_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REC_W = TS_W + WIDTH_W + EDGE_W + 1;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = {WIDTH_W{1'b1}};
    localparam logic [EDGE_W-1:0]  EDGE_MAX  = {EDGE_W{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic e_meta, e_sync, d_meta, d_sync, d_prev;
    logic env, env_prev, env_rise;
    logic [1:0] flush;
    logic armed;

    logic [TS_W-1:0]    start_ts;
    logic [WIDTH_W-1:0] width;
    logic [EDGE_W-1:0]  edges;
    logic               sat;

    logic pulse_end, push_req, push_ok, pop, full, empty;
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [REC_W-1:0]   head;

    assign env = ~e_sync;

    // Two-flop synchronisers plus edge history. The pulse detector is only
    // armed once the synchronisers have flushed and the envelope has been
    // seen idle, so light already present at reset never opens a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_meta   <= 1'b1;
            e_sync   <= 1'b1;
            d_meta   <= 1'b1;
            d_sync   <= 1'b1;
            d_prev   <= 1'b1;
            env_prev <= 1'b0;
            flush    <= 2'b00;
            armed    <= 1'b0;
        end else begin
            e_meta   <= io_e;
            e_sync   <= e_meta;
            d_meta   <= io_d;
            d_sync   <= d_meta;
            d_prev   <= d_sync;
            env_prev <= env;
            flush    <= {flush[0], 1'b1};
            if (flush[1] && !env)
                armed <= 1'b1;
        end
    end

    assign env_rise = armed & env & ~env_prev;

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (env_rise) state_nxt = S_PULSE;
            S_PULSE: if (!env)     state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: end-of-pulse strobe and the qualified FIFO push request.
    always_comb begin
        pulse_end = 1'b0;
        push_req  = 1'b0;
        if (state == S_PULSE && !env) begin
            pulse_end = 1'b1;
            push_req  = (width >= WIDTH_W'(MIN_WIDTH));
        end
    end

    // Pulse measurement: capture on rising edge, count while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_ts <= '0;
            width    <= '0;
            edges    <= '0;
            sat      <= 1'b0;
        end else if (state == S_IDLE && env_rise) begin
            start_ts <= io_timestamp;
            width    <= WIDTH_W'(1);
            edges    <= '0;
            sat      <= 1'b0;
        end else if (state == S_PULSE && env) begin
            if (width != WIDTH_MAX) begin
                width <= width + WIDTH_W'(1);
                if (width == WIDTH_MAX - WIDTH_W'(1))
                    sat <= 1'b1;
            end
            if (d_sync != d_prev && edges != EDGE_MAX) begin
                edges <= edges + EDGE_W'(1);
                if (edges == EDGE_MAX - EDGE_W'(1))
                    sat <= 1'b1;
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = io_pulse_valid & io_pulse_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when the consumer is draining.
    assign push_ok = push_req & (~full | pop);

    // Record FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            io_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[PTR_W-1:0]] <= {start_ts, width, edges, sat};
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (push_req && full && !pop)
                io_overflow <= 1'b1;
        end
    end

    assign head           = mem[rd_ptr[PTR_W-1:0]];
    assign io_pulse_valid = ~empty;
    assign {io_pulse_timestamp, io_pulse_width, io_pulse_edges, io_pulse_saturated} = head;

endmodule

// File: tb/tb_ts4231_pulse_capture.sv
// Self-checking bench for ts4231_pulse_capture: pulse table plus hand-written
// overflow, reset and full-FIFO sequences, with a record scoreboard.
module tb_ts4231_pulse_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_e = 1'b1;
    logic        io_d = 1'b0;
    logic        ready = 1'b1;
    logic [23:0] ts_cnt = '0;

    logic        io_pulse_valid;
    logic [23:0] io_pulse_timestamp;
    logic [15:0] io_pulse_width;
    logic [7:0]  io_pulse_edges;
    logic        io_pulse_saturated;
    logic        io_overflow;

    typedef struct packed {
        logic [23:0] ts;
        logic [15:0] width;
        logic [7:0]  edges;
        logic        sat;
    } rec_t;

    typedef struct {
        int          len;
        int          toggles;
        int          gap;
        bit          emit;
        logic [15:0] w;
        logic [7:0]  edg;
        logic        sat;
    } vec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    ts4231_pulse_capture dut (
        .clk                (clk),
        .reset              (reset),
        .io_e               (io_e),
        .io_d               (io_d),
        .io_timestamp       (ts_cnt),
        .io_pulse_valid     (io_pulse_valid),
        .io_pulse_ready     (ready),
        .io_pulse_timestamp (io_pulse_timestamp),
        .io_pulse_width     (io_pulse_width),
        .io_pulse_edges     (io_pulse_edges),
        .io_pulse_saturated (io_pulse_saturated),
        .io_overflow        (io_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ts_cnt <= ts_cnt + 24'd1;

    // Scoreboard: every handshake seen mid-cycle is compared with the oldest expectation.
    always @(negedge clk) begin
        rec_t got;
        rec_t expv;
        if (!reset && io_pulse_valid && ready) begin
            got = {io_pulse_timestamp, io_pulse_width, io_pulse_edges, io_pulse_saturated};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record actual=%h required=none", got);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    failures++;
                    $display("FAIL record actual=%h required=%h", got, expv);
                end
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds e low for len cycles, toggling d inside the pulse; optionally
    // queues the record the DUT should produce (start = drive-time ts + 2).
    task automatic pulse(int len, int toggles, bit emit, logic [15:0] w, logic [7:0] edg, logic sat);
        int   cnt;
        rec_t r;
        cnt = 0;
        r.ts    = ts_cnt + 24'd2;
        r.width = w;
        r.edges = edg;
        r.sat   = sat;
        if (emit)
            exp_q.push_back(r);
        for (int i = 0; i < len; i++) begin
            if (i == 0)
                io_e = 1'b0;
            if (i >= 4 && (i - 4) % 3 == 0 && cnt < toggles && i <= len - 5) begin
                io_d = ~io_d;
                cnt++;
            end
            step(1);
        end
        io_e = 1'b1;
    endtask

    task automatic drain(string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            step(1);
            g++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[7];
        int   valid_seen;
        int   guard;

        tbl[0] = '{len: 3,     toggles: 0,   gap: 10, emit: 1'b0, w: 16'd0,     edg: 8'd0,   sat: 1'b0};
        tbl[1] = '{len: 4,     toggles: 0,   gap: 10, emit: 1'b1, w: 16'd4,     edg: 8'd0,   sat: 1'b0};
        tbl[2] = '{len: 1,     toggles: 0,   gap: 10, emit: 1'b0, w: 16'd0,     edg: 8'd0,   sat: 1'b0};
        tbl[3] = '{len: 9,     toggles: 1,   gap: 10, emit: 1'b1, w: 16'd9,     edg: 8'd1,   sat: 1'b0};
        tbl[4] = '{len: 50,    toggles: 3,   gap: 10, emit: 1'b1, w: 16'd50,    edg: 8'd3,   sat: 1'b0};
        tbl[5] = '{len: 1000,  toggles: 300, gap: 10, emit: 1'b1, w: 16'd1000,  edg: 8'd255, sat: 1'b1};
        tbl[6] = '{len: 70000, toggles: 0,   gap: 10, emit: 1'b1, w: 16'd65535, edg: 8'd0,   sat: 1'b1};

        // Reset values.
        reset = 1'b1;
        step(3);
        check("rst_valid", io_pulse_valid, 0);
        check("rst_overflow", io_overflow, 0);
        check("rst_data", {io_pulse_timestamp, io_pulse_width, io_pulse_edges, io_pulse_saturated}, 0);
        reset = 1'b0;

        // 100-cycle pulse driven when the timestamp reads 0x10.
        guard = 0;
        while (ts_cnt != 24'h10 && guard < 100) begin
            step(1);
            guard++;
        end
        check("ts_align", ts_cnt, 24'h10);
        exp_q.push_back(rec_t'{ts: 24'h000012, width: 16'd100, edges: 8'd6, sat: 1'b0});
        pulse(100, 6, 1'b0, 16'd0, 8'd0, 1'b0);
        step(10);
        drain("rec_ts10");

        // Idle sensor produces nothing.
        valid_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (io_pulse_valid) valid_seen++;
            step(1);
        end
        check("idle_valid", valid_seen, 0);
        check("idle_overflow", io_overflow, 0);

        // Table of single pulses with ready held high.
        foreach (tbl[k]) begin
            pulse(tbl[k].len, tbl[k].toggles, tbl[k].emit, tbl[k].w, tbl[k].edg, tbl[k].sat);
            step(tbl[k].gap);
        end
        drain("table_drain");

        // Six pulses with no consumer: four held, two dropped.
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pulse(20, 0, (k < 4), 16'd20, 8'd0, 1'b0);
            step(10);
        end
        check("ovf_valid", io_pulse_valid, 1);
        check("ovf_flag", io_overflow, 1);
        check("ovf_head_ts", io_pulse_timestamp, exp_q[0].ts);
        step(5);
        check("ovf_head_stable", io_pulse_timestamp, exp_q[0].ts);
        ready = 1'b1;
        drain("ovf_drain");
        step(3);
        check("ovf_empty_valid", io_pulse_valid, 0);

        // Overflow is sticky until reset.
        reset = 1'b1;
        step(2);
        check("ovf_cleared", io_overflow, 0);
        reset = 1'b0;
        step(5);

        // Reset in the middle of a pulse discards it.
        io_e = 1'b0;
        step(50);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(48);
        io_e = 1'b1;
        step(20);
        check("midrst_valid", io_pulse_valid, 0);
        check("midrst_queue", exp_q.size(), 0);
        pulse(30, 2, 1'b1, 16'd30, 8'd2, 1'b0);
        step(15);
        drain("post_rst_pulse");

        // Full FIFO with a pop in the same cycle as the next push.
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pulse(20, 0, 1'b1, 16'd20, 8'd0, 1'b0);
            step(10);
        end
        pulse(25, 0, 1'b1, 16'd25, 8'd0, 1'b0);
        step(2);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(3);
        check("fullpop_overflow", io_overflow, 0);
        check("fullpop_valid", io_pulse_valid, 1);
        check("fullpop_queue", exp_q.size(), 4);
        check("fullpop_head_ts", io_pulse_timestamp, exp_q[0].ts);
        ready = 1'b1;
        drain("fullpop_drain");
        step(3);
        check("fullpop_empty", io_pulse_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
